// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon state type, round-constant commands and permutation constants
package ascon_pkg;
  typedef logic [319:0] ascon_state_t;
  typedef enum logic [1:0] {
    RC_HOLD = 2'b00,
    RC_LOAD = 2'b01,
    RC_ADV  = 2'b10
  } rcmode_e;
  localparam int P12_ROUNDS = 12;
  localparam int P6_ROUNDS = 6;
  localparam int P12_START = 0;
  localparam int P6_START = 6;
endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// ascon_perm_ctrl_if: host handshake bus (state in via in_*, result out via out_*); master = host, slave = controller
interface ascon_perm_ctrl_if;
  import ascon_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_p12;
  ascon_state_t in_state;
  logic out_valid;
  logic out_ready;
  ascon_state_t out_state;
  modport master (
    output in_valid, in_p12, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );
  modport slave (
    input  in_valid, in_p12, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: Ascon p12/p6 round controller; host bus in/out, rcmode/constti to round-constant unit, Xi to and Xo from external datapath
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic clk,
  input  logic RST,
  ascon_perm_ctrl_if.slave bus,
  output logic [1:0] rcmode,
  output logic [3:0] constti,
  output logic [63:0] Xi0,
  output logic [63:0] Xi1,
  output logic [63:0] Xi2,
  output logic [63:0] Xi3,
  output logic [63:0] Xi4,
  input  logic [63:0] Xo0,
  input  logic [63:0] Xo1,
  input  logic [63:0] Xo2,
  input  logic [63:0] Xo3,
  input  logic [63:0] Xo4
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 6) begin : g_bad_unroll
    $error("ascon_perm_ctrl: UNROLL must be 1, 2, 3 or 6");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [3:0] CNT12 = 4'(P12_ROUNDS / UNROLL);
  localparam logic [3:0] CNT6 = 4'(P6_ROUNDS / UNROLL);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ascon_state_t out_q, out_d;
  ascon_state_t xo;
  logic accept;
  assign xo = {Xo0, Xo1, Xo2, Xo3, Xo4};
  assign accept = bus.in_valid && state_q == IDLE;
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (accept ? RUN : IDLE) :
              state_q == RUN  ? (cnt_q == 4'd1 ? DONE : RUN) :
                                (bus.out_ready ? IDLE : DONE);
    cnt_d = accept ? (bus.in_p12 ? CNT12 : CNT6) : state_q == RUN ? cnt_q - 4'd1 : cnt_q;
    out_d = (state_q == RUN && cnt_q == 4'd1) ? xo : out_q;
  end
  always_comb begin
    bus.in_ready = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.out_state = out_q;
    rcmode = state_q == IDLE ? RC_LOAD : state_q == RUN ? RC_ADV : RC_HOLD;
    constti = bus.in_p12 ? 4'(P12_START) : 4'(P6_START);
    {Xi0, Xi1, Xi2, Xi3, Xi4} = state_q == RUN ? xo : bus.in_state;
  end
endmodule
